// File: rtl/vad_decision.sv
// Smooths per-frame speech/noise MAC results into a voice-activity flag via an onset/hangover FSM.
// Results are registered one clock after the rising edge of mac_done; there is no backpressure.
module vad_decision #(
  parameter int ONSET_FRAMES = 2,
  parameter int HANG_FRAMES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mac_out,
  input  logic        mac_done,
  output logic        vad_flag,
  output logic        vad_valid,
  output logic [1:0]  vad_state,
  output logic        speech_start,
  output logic        speech_end,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    SILENCE  = 2'b00,
    ONSET    = 2'b01,
    SPEECH   = 2'b10,
    HANGOVER = 2'b11
  } state_t;

  localparam logic [3:0] ONSET_LIM = 4'(ONSET_FRAMES);
  localparam logic [7:0] HANG_INIT = (HANG_FRAMES > 0) ? 8'(HANG_FRAMES - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [3:0]  onset_q, onset_d;
  logic [7:0]  hang_q, hang_d;
  logic        last_raw_q, last_raw_d;
  logic        done_q;
  logic        flag_q;
  logic        valid_q;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic [15:0] fcnt_q;
  logic        frame_ev;
  logic        raw;

  assign frame_ev = mac_done & ~done_q;
  // A tie (00/11) inherits the previous frame's class.
  assign raw = (mac_out == 2'b10) ? 1'b1 : (mac_out == 2'b01) ? 1'b0 : last_raw_q;

  always_comb begin
    state_d    = state_q;
    onset_d    = onset_q;
    hang_d     = hang_q;
    last_raw_d = last_raw_q;
    start_d    = 1'b0;
    end_d      = 1'b0;
    if (frame_ev) begin
      last_raw_d = raw;
      unique case (state_q)
        SILENCE: begin
          if (raw) begin
            if (ONSET_FRAMES == 1) begin
              state_d = SPEECH;
              start_d = 1'b1;
            end else begin
              state_d = ONSET;
              onset_d = 4'd1;
            end
          end
        end
        ONSET: begin
          if (raw) begin
            if (onset_q + 4'd1 == ONSET_LIM) begin
              state_d = SPEECH;
              onset_d = 4'd0;
              start_d = 1'b1;
            end else begin
              onset_d = onset_q + 4'd1;
            end
          end else begin
            state_d = SILENCE;
            onset_d = 4'd0;
          end
        end
        SPEECH: begin
          if (!raw) begin
            if (HANG_FRAMES == 0) begin
              state_d = SILENCE;
              end_d   = 1'b1;
            end else begin
              state_d = HANGOVER;
              hang_d  = HANG_INIT;
            end
          end
        end
        HANGOVER: begin
          if (raw) begin
            state_d = SPEECH;
          end else if (hang_q == 8'd0) begin
            state_d = SILENCE;
            end_d   = 1'b1;
          end else begin
            hang_d = hang_q - 8'd1;
          end
        end
        default: state_d = SILENCE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SILENCE;
      onset_q    <= 4'd0;
      hang_q     <= 8'd0;
      last_raw_q <= 1'b0;
      done_q     <= 1'b0;
      flag_q     <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      fcnt_q     <= 16'd0;
    end else begin
      done_q     <= mac_done;
      state_q    <= state_d;
      onset_q    <= onset_d;
      hang_q     <= hang_d;
      last_raw_q <= last_raw_d;
      valid_q    <= frame_ev;
      start_q    <= start_d;
      end_q      <= end_d;
      if (frame_ev) begin
        flag_q <= (state_d == SPEECH) || (state_d == HANGOVER);
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  assign vad_flag     = flag_q;
  assign vad_valid    = valid_q;
  assign vad_state    = state_q;
  assign speech_start = start_q;
  assign speech_end   = end_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_vad_decision.sv
// Bench for vad_decision: two instances (defaults, and ONSET=1/HANG=0) share one stimulus stream.
module tb_vad_decision;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mac_out;
  logic        mac_done;
  logic        f0, v0, s0, e0, f1, v1, s1, e1;
  logic [1:0]  st0, st1;
  logic [15:0] fc0, fc1;

  int vectors = 0;
  int errors  = 0;

  vad_decision dut0 (
    .clk(clk), .rst_n(rst_n), .mac_out(mac_out), .mac_done(mac_done),
    .vad_flag(f0), .vad_valid(v0), .vad_state(st0),
    .speech_start(s0), .speech_end(e0), .frame_cnt(fc0)
  );

  vad_decision #(.ONSET_FRAMES(1), .HANG_FRAMES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .mac_out(mac_out), .mac_done(mac_done),
    .vad_flag(f1), .vad_valid(v1), .vad_state(st1),
    .speech_start(s1), .speech_end(e1), .frame_cnt(fc1)
  );

  // Reference model: tracks run lengths of speech/noise frames rather than a state encoding.
  int          ons[2] = '{2, 1};
  int          hng[2] = '{8, 0};
  bit          m_in[2];
  int          m_srun[2];
  int          m_nrun[2];
  bit          m_last[2];
  bit          prev_done;
  logic [1:0]  x_state[2];
  logic        x_flag[2], x_valid[2], x_start[2], x_end[2];
  logic [15:0] x_fcnt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 0; m_srun[i] = 0; m_nrun[i] = 0; m_last[i] = 0;
      x_state[i] = 2'b00; x_flag[i] = 0; x_valid[i] = 0;
      x_start[i] = 0; x_end[i] = 0; x_fcnt[i] = 16'd0;
    end
    prev_done = 0;
  endtask

  task automatic model_frame(input int i, input logic [1:0] o);
    bit sp;
    sp = (o == 2'b10) ? 1'b1 : (o == 2'b01) ? 1'b0 : m_last[i];
    m_last[i]  = sp;
    x_valid[i] = 1;
    x_fcnt[i]  = x_fcnt[i] + 16'd1;
    if (!m_in[i]) begin
      m_srun[i] = sp ? m_srun[i] + 1 : 0;
      if (m_srun[i] >= ons[i]) begin
        m_in[i] = 1; m_srun[i] = 0; m_nrun[i] = 0; x_start[i] = 1;
      end
    end else begin
      m_nrun[i] = sp ? 0 : m_nrun[i] + 1;
      if (m_nrun[i] > hng[i]) begin
        m_in[i] = 0; m_nrun[i] = 0; m_srun[i] = 0; x_end[i] = 1;
      end
    end
    x_flag[i]  = m_in[i];
    x_state[i] = m_in[i] ? ((m_nrun[i] == 0) ? 2'b10 : 2'b11)
                         : ((m_srun[i] == 0) ? 2'b00 : 2'b01);
  endtask

  task automatic cycle(input logic d, input logic [1:0] o);
    @(negedge clk);
    mac_done = d;
    mac_out  = o;
    for (int i = 0; i < 2; i++) begin
      x_valid[i] = 0; x_start[i] = 0; x_end[i] = 0;
    end
    if (rst_n && mac_done && !prev_done)
      for (int i = 0; i < 2; i++) model_frame(i, o);
    prev_done = rst_n ? mac_done : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fr(input logic [1:0] o);
    cycle(1'b0, 2'b00);
    cycle(1'b1, o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    mac_done = 1'b0;
    mac_out  = 2'b00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mac_done = 1'b0; mac_out = 2'b00;
    #3;
    vectors++;
    if ({f0, v0, st0, s0, e0, fc0, f1, v1, st1, s1, e1, fc1} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b want all zero",
               {f0, v0, st0, s0, e0, fc0}, {f1, v1, st1, s1, e1, fc1});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_onset();
    logic [1:0] wst[3] = '{2'b01, 2'b10, 2'b10};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fr(2'b10);
      vectors++;
      if ({v0, f0, s0, e0, st0} !== {1'b1, k != 0, k == 1, 1'b0, wst[k]}) begin
        errors++;
        $display("FAIL onset frame%0d got v/f/s/e/st=%b want %b", k + 1,
                 {v0, f0, s0, e0, st0}, {1'b1, k != 0, k == 1, 1'b0, wst[k]});
      end
      cycle(1'b0, 2'b00);
      vectors++;
      if ({v0, s0, f0} !== {1'b0, 1'b0, k != 0}) begin
        errors++;
        $display("FAIL onset_idle%0d got v/s/f=%b want %b", k + 1, {v0, s0, f0}, {1'b0, 1'b0, k != 0});
      end
    end
  endtask

  task automatic test_hangover();
    for (int k = 1; k <= 9; k++) begin
      fr(2'b01);
      vectors++;
      if ({f0, e0, s0, st0} !== {k < 9, k == 9, 1'b0, (k < 9) ? 2'b11 : 2'b00}) begin
        errors++;
        $display("FAIL hangover noise%0d got f/e/s/st=%b want %b", k,
                 {f0, e0, s0, st0}, {k < 9, k == 9, 1'b0, (k < 9) ? 2'b11 : 2'b00});
      end
    end
  endtask

  task automatic test_return();
    do_reset();
    fr(2'b10); fr(2'b10);
    fr(2'b01); fr(2'b01); fr(2'b01);
    vectors++;
    if (st0 !== 2'b11) begin
      errors++; $display("FAIL return_in_hang got st=%b want 11", st0);
    end
    fr(2'b10);
    vectors++;
    if ({st0, f0, s0, e0} !== {2'b10, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL return_speech got st/f/s/e=%b want 10100", {st0, f0, s0, e0});
    end
    for (int k = 1; k <= 9; k++) begin
      fr(2'b01);
      vectors++;
      if ({e0, f0} !== {k == 9, k < 9}) begin
        errors++; $display("FAIL return_noise%0d got e/f=%b want %b", k, {e0, f0}, {k == 9, k < 9});
      end
    end
  endtask

  task automatic test_tie();
    logic [15:0] c;
    do_reset();
    fr(2'b10);
    fr(2'b11);
    vectors++;
    if ({s0, st0} !== 3'b110) begin
      errors++; $display("FAIL tie_start got s/st=%b want 110", {s0, st0});
    end
    fr(2'b00);
    vectors++;
    if ({s0, st0, f0} !== 4'b0101) begin
      errors++; $display("FAIL tie_hold got s/st/f=%b want 0101", {s0, st0, f0});
    end
    cycle(1'b0, 2'b00);
    c = fc0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 2'b01);
      vectors++;
      if (v0 !== (k == 0)) begin
        errors++; $display("FAIL held_done_valid cyc%0d got %b want %b", k, v0, k == 0);
      end
    end
    vectors++;
    if (fc0 !== c + 16'd1) begin
      errors++; $display("FAIL held_done_cnt got %0d want %0d", fc0, c + 16'd1);
    end
  endtask

  task automatic test_short_cfg();
    do_reset();
    fr(2'b10);
    vectors++;
    if ({s1, e1, f1, st1} !== 5'b10110) begin
      errors++; $display("FAIL cfg1_frame1 got s/e/f/st=%b want 10110", {s1, e1, f1, st1});
    end
    fr(2'b01);
    vectors++;
    if ({s1, e1, f1, st1} !== 5'b01000) begin
      errors++; $display("FAIL cfg1_frame2 got s/e/f/st=%b want 01000", {s1, e1, f1, st1});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fr(2'b10); fr(2'b10); fr(2'b01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({f0, v0, st0, s0, e0, fc0} !== 22'd0) begin
      errors++; $display("FAIL async_reset got %b want 0", {f0, v0, st0, s0, e0, fc0});
    end
    mac_done = 1'b1; mac_out = 2'b10;
    @(posedge clk); #1;
    vectors++;
    if ({v0, fc0} !== 17'd0) begin
      errors++; $display("FAIL reset_discard got v/fc=%b want 0", {v0, fc0});
    end
    @(negedge clk);
    mac_done = 1'b0;
    rst_n = 1'b1;
    model_reset();
    fr(2'b10);
    vectors++;
    if ({st0, v0, fc0} !== {2'b01, 1'b1, 16'd1}) begin
      errors++; $display("FAIL after_reset got st=%b v=%b fc=%0d want 01 1 1", st0, v0, fc0);
    end
    @(negedge clk);
    rst_n = 1'b0; mac_done = 1'b1; mac_out = 2'b10;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({v0, st0, fc0} !== {1'b1, 2'b01, 16'd1}) begin
      errors++; $display("FAIL release_high got v=%b st=%b fc=%0d want 1 01 1", v0, st0, fc0);
    end
  endtask

  task automatic test_random();
    logic [1:0] o;
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      o = (r < 40) ? 2'b10 : (r < 75) ? 2'b01 : (r < 88) ? 2'b00 : 2'b11;
      cycle($urandom_range(0, 1) == 1, o);
      vectors++;
      if ({st0, f0, v0, s0, e0, fc0} !== {x_state[0], x_flag[0], x_valid[0], x_start[0], x_end[0], x_fcnt[0]}) begin
        errors++;
        $display("FAIL random_dut0 cyc%0d got %h want %h", n, {st0, f0, v0, s0, e0, fc0},
                 {x_state[0], x_flag[0], x_valid[0], x_start[0], x_end[0], x_fcnt[0]});
      end
      vectors++;
      if ({st1, f1, v1, s1, e1, fc1} !== {x_state[1], x_flag[1], x_valid[1], x_start[1], x_end[1], x_fcnt[1]}) begin
        errors++;
        $display("FAIL random_dut1 cyc%0d got %h want %h", n, {st1, f1, v1, s1, e1, fc1},
                 {x_state[1], x_flag[1], x_valid[1], x_start[1], x_end[1], x_fcnt[1]});
      end
      vectors++;
      if (((s0 & e0) | (s1 & e1) | ((s0 | e0) & ~v0) | ((s1 | e1) & ~v1)) !== 1'b0) begin
        errors++; $display("FAIL random_pulses cyc%0d got s/e/v=%b want exclusive", n, {s0, e0, v0, s1, e1, v1});
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 65535; k++) fr(2'b01);
    vectors++;
    if (fc0 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got %0d want 65535", fc0);
    end
    fr(2'b01);
    vectors++;
    if ({fc0, v0, st0, f0} !== {16'd0, 1'b1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL wrap got fc=%0d v=%b st=%b f=%b want 0 1 00 0", fc0, v0, st0, f0);
    end
  endtask

  initial begin
    test_reset();
    test_onset();
    test_hangover();
    test_return();
    test_tie();
    test_short_cfg();
    test_async_reset();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
